// File: rtl/pipeline_register_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_register_skid
// Description : Valid/ready pipeline stage register with a 2-entry skid
//               buffer, registered upstream ready, synchronous flush and a
//               saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_register_skid #(
    parameter int               N       = 32,
    parameter logic [N-1:0]     CLR_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [N-1:0]     main_q, main_d;
    logic [N-1:0]     skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_accept;
    logic w_consume;
    logic w_out_valid;

    assign w_out_valid = (state_q != S_EMPTY);
    assign w_accept    = in_valid & in_ready_q;
    assign w_consume   = w_out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            state_d = S_EMPTY;
            main_d  = CLR_VAL;
            skid_d  = CLR_VAL;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end else begin
                        main_d  = CLR_VAL;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        main_d  = in_data;
                    end else if (w_accept) begin
                        skid_d  = in_data;
                        state_d = S_FULL;
                    end else if (w_consume) begin
                        main_d  = CLR_VAL;
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_consume) begin
                        main_d  = skid_q;
                        skid_d  = CLR_VAL;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = CLR_VAL;
                    skid_d  = CLR_VAL;
                end
            endcase

            if (w_out_valid && !out_ready && (stall_cnt_q != C_CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + C_CNT_ONE;
            end
        end

        in_ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_EMPTY;
            main_q      <= CLR_VAL;
            skid_q      <= CLR_VAL;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = w_out_valid;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_register_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_register_skid
// Description : Self-checking bench: directed vector table, hand sequences
//               for saturation/async reset, and randomized queue-model run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_register_skid;

    localparam int           N       = 32;
    localparam int           CNT_W   = 4;
    localparam logic [N-1:0] CLR     = '0;
    localparam int           SAT     = 15;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of held words and a saturating counter.
    logic [N-1:0] mq[$];
    int           mstall;
    bit           m_in_ready;

    pipeline_register_skid #(.N(N), .CLR_VAL(CLR), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [N-1:0] d;
        logic         r;
        logic         f;
        logic         ev;
        logic [N-1:0] ed;
        logic [1:0]   eo;
        logic         eir;
        logic [3:0]   es;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mstall     = 0;
        m_in_ready = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, N'(out_valid), N'(mq.size() > 0));
        chk({tag, ".out_data"},  out_data, (mq.size() > 0) ? mq[0] : CLR);
        chk({tag, ".occupancy"}, N'(occupancy), N'(mq.size()));
        chk({tag, ".in_ready"},  N'(in_ready), N'(m_in_ready));
        chk({tag, ".stall_cnt"}, N'(stall_cnt), N'(mstall));
    endtask

    // Apply inputs for one edge, advance the model, land 1 time unit after the edge.
    task automatic step(input logic v, input logic [N-1:0] d, input logic r, input logic f);
        bit acc, cons, stl;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc  = v && m_in_ready;
        cons = (mq.size() > 0) && r;
        stl  = (mq.size() > 0) && !r && !f;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (cons) void'(mq.pop_front());
            if (acc)  mq.push_back(d);
        end
        if (stl && mstall < SAT) mstall++;
        m_in_ready = (mq.size() < 2);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        //              v     d             r     f     ev    ed            eo    eir   es
        tbl[0]  = '{1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b1, 32'h00A00093, 2'd1, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 32'h00000011, 1'b1, 1'b0, 1'b1, 32'h00000011, 2'd1, 1'b1, 4'd0};
        tbl[2]  = '{1'b1, 32'h00000022, 1'b1, 1'b0, 1'b1, 32'h00000022, 2'd1, 1'b1, 4'd0};
        tbl[3]  = '{1'b1, 32'h00000033, 1'b1, 1'b0, 1'b1, 32'h00000033, 2'd1, 1'b1, 4'd0};
        tbl[4]  = '{1'b1, 32'h00000044, 1'b1, 1'b0, 1'b1, 32'h00000044, 2'd1, 1'b1, 4'd0};
        tbl[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 2'd0, 1'b1, 4'd0};
        tbl[6]  = '{1'b1, 32'h000000A1, 1'b0, 1'b0, 1'b1, 32'h000000A1, 2'd1, 1'b1, 4'd0};
        tbl[7]  = '{1'b1, 32'h000000A2, 1'b0, 1'b0, 1'b1, 32'h000000A1, 2'd2, 1'b0, 4'd1};
        tbl[8]  = '{1'b1, 32'h000000A3, 1'b0, 1'b0, 1'b1, 32'h000000A1, 2'd2, 1'b0, 4'd2};
        tbl[9]  = '{1'b1, 32'h000000A3, 1'b1, 1'b0, 1'b1, 32'h000000A2, 2'd1, 1'b1, 4'd2};
        tbl[10] = '{1'b1, 32'h000000A3, 1'b1, 1'b0, 1'b1, 32'h000000A3, 2'd1, 1'b1, 4'd2};
        tbl[11] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 2'd0, 1'b1, 4'd2};
        tbl[12] = '{1'b1, 32'h000000B1, 1'b0, 1'b0, 1'b1, 32'h000000B1, 2'd1, 1'b1, 4'd2};
        tbl[13] = '{1'b1, 32'h000000B2, 1'b0, 1'b0, 1'b1, 32'h000000B1, 2'd2, 1'b0, 4'd3};
        tbl[14] = '{1'b1, 32'h000000B3, 1'b0, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1, 4'd3};
        tbl[15] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 2'd0, 1'b1, 4'd3};

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.out_valid", N'(out_valid), N'(0));
        chk("rst.in_ready",  N'(in_ready),  N'(1));
        chk("rst.out_data",  out_data,      CLR);
        chk("rst.occupancy", N'(occupancy), N'(0));
        chk("rst.stall_cnt", N'(stall_cnt), N'(0));

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk($sformatf("vec%0d.out_valid", i), N'(out_valid), N'(tbl[i].ev));
            chk($sformatf("vec%0d.out_data", i),  out_data,      tbl[i].ed);
            chk($sformatf("vec%0d.occupancy", i), N'(occupancy), N'(tbl[i].eo));
            chk($sformatf("vec%0d.in_ready", i),  N'(in_ready),  N'(tbl[i].eir));
            chk($sformatf("vec%0d.stall_cnt", i), N'(stall_cnt), N'(tbl[i].es));
        end

        // Saturation: counter already at 3, twenty more stalled cycles
        step(1'b1, 32'h000000C1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("sat.stall_cnt", N'(stall_cnt), N'(15));
        step(1'b0, '0, 1'b0, 1'b0);
        chk("sat.hold", N'(stall_cnt), N'(15));
        check_model("sat");

        // Asynchronous reset mid-stall, observed before any clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("arst.stall_cnt", N'(stall_cnt), N'(0));
        chk("arst.out_valid", N'(out_valid), N'(0));
        chk("arst.out_data",  out_data,      CLR);
        chk("arst.in_ready",  N'(in_ready),  N'(1));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 32'h000000D1, 1'b1, 1'b0);
        check_model("post_rst");

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 70),
                 N'($urandom),
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 4));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_register_skid.md
Name: pipeline_register_skid

Overview:
- Parametrised successor to the plain enable/clear stage register between pipeline stages (e.g. Fetch->Decode).
- Adds a full valid/ready handshake on both sides and a 2-entry skid buffer, so the upstream ready is registered and throughput stays at one word per cycle.
- Adds a synchronous flush that inserts a bubble value, plus a saturating stall counter for performance monitoring.
- Sits between any two stages of the SIMD pipeline; the Decode-side consumer back-pressures through out_ready.

Parameters:
- N, 32, data word width (instruction or packed stage payload).
- CLR_VAL, 0 (N bits), bubble value driven on out_data when the stage is empty or after flush/reset (all-zero = NOP).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- flush  input  1  synchronous clear; drops all held and incoming data.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
- in_data  input  N  upstream word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  N  head word, or CLR_VAL when empty.
- occupancy  output  2  number of held words: 0, 1 or 2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready. Data moves only on these events.
- Storage: main register drives out_data; skid register is used only when a word is accepted while the main register is held.
- States and outputs:
  - EMPTY (occ=0): out_valid=0, in_ready=1.
  - ONE (occ=1): out_valid=1, in_ready=1.
  - FULL (occ=2): out_valid=1, in_ready=0.
- Transitions, evaluated at the clock edge when flush=0:
  - EMPTY: accept -> main<=in_data, go ONE. Otherwise stay EMPTY; main holds CLR_VAL.
  - ONE, accept & consume -> main<=in_data, stay ONE.
  - ONE, accept & !consume -> skid<=in_data, go FULL.
  - ONE, !accept & consume -> main<=CLR_VAL, go EMPTY.
  - ONE, neither -> hold.
  - FULL, consume -> main<=skid, skid<=CLR_VAL, go ONE.
  - FULL, otherwise -> hold. in_valid is ignored because in_ready=0.
- Ordering is strict FIFO: the main word always leaves before the skid word.
- Latency: a word accepted in cycle t appears on out_data with out_valid=1 in cycle t+1, provided it enters the main register.
- Throughput: sustained 1 word/cycle while out_ready=1.
- in_ready is a flop equal to (next state != FULL). It is updated on the same edge as the state.
- Flush has priority over every other event in that cycle:
  - Next state EMPTY; main and skid <= CLR_VAL; in_ready <= 1.
  - A word presented with in_valid that cycle is dropped.
  - Any consume in the same cycle still counts as a transfer to downstream.
  - stall_cnt is not cleared.
- Reset (rst=0), asynchronous: state EMPTY, out_valid=0, in_ready=1, out_data=CLR_VAL, skid=CLR_VAL, occupancy=0, stall_cnt=0.
  - Reset mid-transfer discards held words.
  - After reset is released, the first edge behaves as EMPTY.
- stall_cnt: +1 on every edge with out_valid=1 & out_ready=0 & flush=0. It holds at 2^CNT_W-1 once saturated and never wraps.
- No X propagation: out_data equals CLR_VAL exactly whenever out_valid=0.

Test Plan:
- Reset/idle: hold rst=0, then release. Required: out_valid=0, in_ready=1, out_data=0x00000000, occupancy=0, stall_cnt=0. Drive in_valid=1, in_data=0x00A00093 for one cycle. Required: next cycle out_valid=1, out_data=0x00A00093, occupancy=1.
- Streaming: send 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=1. Required: out_data is 0x11..0x44 on the 4 following cycles, in_ready stays 1, occupancy never exceeds 1.
- Skid/back-pressure: with out_ready=0, send 0xA1 then 0xA2. Required: occupancy=2, in_ready=0 on the next cycle, out_data=0xA1. 0xA3 held on in_data is not accepted. Raise out_ready. Required: outputs 0xA1, 0xA2, then 0xA3 once accepted, with no loss or duplication.
- Flush: in FULL (0xB1, 0xB2 held), assert flush with in_valid=1, in_data=0xB3. Required: next cycle occupancy=0, out_valid=0, out_data=CLR_VAL, in_ready=1; 0xB3 never appears on out_data.
- Stall counter: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt=15, which then stays at 15. Assert rst=0 mid-stall. Required: stall_cnt=0 and out_valid=0 immediately, without waiting for a clock edge.
